alu_seq: RTL and testbench

Parametrised, handshaked, multi-cycle successor to the 4-bit combinational ALU. It accepts one operation at a time over a valid/ready input channel and computes it:
- logic, add, sub and shift in one cycle;
- multiply (shift-add) and divide (restoring) iteratively over WIDTH cycles.

It returns registered results over a valid/ready output channel. It sits between the operand/opcode source and the result consumer, and replaces the direct combinational ALU path.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_muldiv_iter.sv | 86 ++++++++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, opcode classes,
// FSM state encoding and iterative-engine mode select.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_NOT   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_RSV   = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1100;

  // Upper two opcode bits select the operation class.
  typedef enum logic [1:0] {
    CLS_LOGIC = 2'b00,
    CLS_ARITH = 2'b01,
    CLS_SHIFT = 2'b10,
    CLS_DIV   = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    return op_class_e'(op[3:2]);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One bit per cycle; the first bit is processed on the start edge itself.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // acc: product high / partial remainder; sr: multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] acc, sr, opnd;
  iter_mode_e       mode_q;
  logic [CW-1:0]    cnt;
  logic             running;

  logic [WIDTH-1:0] cur_acc, cur_sr, cur_op, nxt_acc, nxt_sr;
  iter_mode_e       cur_mode;
  logic [WIDTH:0]   sum, rem_sh;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cur_acc  = start ? '0 : acc;
    cur_sr   = start ? a : sr;
    cur_op   = start ? b : opnd;
    cur_mode = start ? mode : mode_q;
    sum      = {1'b0, cur_acc} + (cur_sr[0] ? {1'b0, cur_op} : '0);
    rem_sh   = {cur_acc, cur_sr[WIDTH-1]};
    nxt_acc  = sum[WIDTH:1];
    nxt_sr   = {sum[0], cur_sr[WIDTH-1:1]};
    if (cur_mode == MODE_DIV) begin
      if (rem_sh >= {1'b0, cur_op}) begin
        nxt_acc = rem_sh[WIDTH-1:0] - cur_op;
        nxt_sr  = {cur_sr[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = rem_sh[WIDTH-1:0];
        nxt_sr  = {cur_sr[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      done    <= 1'b0;
      cnt     <= CW'(1);
    end else if (running) begin
      if (cnt == LAST) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // NOTE: datapath registers carry no reset; control flags above gate their use.
  always_ff @(posedge clk) begin
    if (start || running) begin
      acc    <= nxt_acc;
      sr     <= nxt_sr;
      opnd   <= cur_op;
      mode_q <= cur_mode;
    end
  end

  assign hi = acc;
  assign lo = sr;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU with registered results. Defining ALU_FLAGS_EN
// adds registered zero/negative/overflow flag outputs.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             shift_dir,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry_out,
  output logic             div_by_zero,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
`endif
);

  state_e state, state_nxt;
  logic   accept, go_iter, capture, req_iter;
  logic   iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] sc_y, sc_hi;
  logic             sc_c, sc_dbz;

  assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign sub_diff = a - b;
  // Divide by zero skips the engine and finishes in one cycle.
  assign req_iter = (opcode == OP_MUL) || ((op_class(opcode) == CLS_DIV) && (b != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    go_iter   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        go_iter   = req_iter;
        state_nxt = req_iter ? CALC : DONE;
      end
      CALC: if (iter_done) begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    sc_y   = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_dbz = 1'b0;
    case (op_class(opcode))
      CLS_LOGIC: case (opcode[1:0])
        2'b00:   sc_y = a & b;
        2'b01:   sc_y = a | b;
        2'b10:   sc_y = a ^ b;
        default: sc_y = ~a;
      endcase
      CLS_ARITH: case (opcode[1:0])
        2'b00: {sc_c, sc_y} = add_sum;
        2'b01: begin
          sc_y = sub_diff;
          sc_c = (a >= b);
        end
        default: sc_y = '0;
      endcase
      CLS_SHIFT: sc_y = shift_dir ? (a >> shift_amt) : (a << shift_amt);
      default: begin
        sc_y   = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (go_iter),
    .mode  ((op_class(opcode) == CLS_DIV) ? MODE_DIV : MODE_MUL),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // Results load on accept (single-cycle ops) or on engine completion, then hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y           <= '0;
      y_hi        <= '0;
      carry_out   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept && !go_iter) begin
      y           <= sc_y;
      y_hi        <= sc_hi;
      carry_out   <= sc_c;
      div_by_zero <= sc_dbz;
    end else if (capture) begin
      y           <= iter_lo;
      y_hi        <= iter_hi;
      carry_out   <= 1'b0;
      div_by_zero <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  logic sc_v;

  always_comb begin
    sc_v = 1'b0;
    if (opcode == OP_ADD)
      sc_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    else if (opcode == OP_SUB)
      sc_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept && !go_iter) begin
      flag_z <= (sc_y == '0);
      flag_n <= sc_y[WIDTH-1];
      flag_v <= sc_v;
    end else if (capture) begin
      flag_z <= (iter_lo == '0);
      flag_n <= iter_lo[WIDTH-1];
      flag_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are modelled at issue time
// and compared, with latency, when the result handshake occurs.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W   = 4;
  localparam int SHW = $clog2(W);

  logic           clk, rst_n, in_valid, in_ready, carry_in, shift_dir;
  logic [W-1:0]   a, b, y, y_hi;
  logic [SHW-1:0] shift_amt;
  logic [3:0]     opcode;
  logic           out_valid, out_ready, carry_out, div_by_zero, busy;
`ifdef ALU_FLAGS_EN
  logic           flag_z, flag_n, flag_v;
`endif

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .shift_amt   (shift_amt),
    .shift_dir   (shift_dir),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .y_hi        (y_hi),
    .carry_out   (carry_out),
    .div_by_zero (div_by_zero),
    .busy        (busy)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_v      (flag_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         c;
    logic         dbz;
    logic         v;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] ia_l, ib_l,
                                 input logic cin, input logic [SHW-1:0] amt, input logic dir);
    exp_t e;
    int ia, ib, sa, sbv, r, s;
    int mask = (1 << W) - 1;
    int half = 1 << (W - 1);
    ia = int'(ia_l);
    ib = int'(ib_l);
    sa  = (ia >= half) ? ia - (1 << W) : ia;
    sbv = (ib >= half) ? ib - (1 << W) : ib;
    e.hi = '0; e.c = 1'b0; e.dbz = 1'b0; e.v = 1'b0; e.lat = 1;
    r = 0;
    casez (op)
      4'b0000: r = ia & ib;
      4'b0001: r = ia | ib;
      4'b0010: r = ia ^ ib;
      4'b0011: r = ~ia & mask;
      4'b0100: begin
        r = ia + ib + int'(cin);
        e.c = 1'(r >> W);
        s = sa + sbv + int'(cin);
        e.v = (s > half - 1) || (s < -half);
      end
      4'b0101: begin
        r = ia - ib;
        e.c = (ia >= ib);
        s = sa - sbv;
        e.v = (s > half - 1) || (s < -half);
      end
      4'b0110: begin
        r = ia * ib;
        e.hi = W'(r >> W);
        e.lat = W + 1;
      end
      4'b0111: r = 0;
      4'b10??: r = dir ? (ia >> amt) : (ia << amt);
      default: begin
        if (ib == 0) begin
          r = mask;
          e.hi = ia_l;
          e.dbz = 1'b1;
        end else begin
          r = ia / ib;
          e.hi = W'(ia % ib);
          e.lat = W + 1;
        end
      end
    endcase
    e.y = W'(r & mask);
    return e;
  endfunction

  // Issue one request; returns on the falling edge after the accept edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, bv,
                      input logic cin, input logic [SHW-1:0] amt, input logic dir);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    opcode = op; a = av; b = bv; carry_in = cin; shift_amt = amt; shift_dir = dir;
    in_valid = 1'b1;
    sb_q.push_back(model(op, av, bv, cin, amt, dir));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare it, optionally backpressure (with a competing request).
  task automatic recv(input int hold, input bit compete);
    exp_t e;
    int lat = 1;
    bit ok_busy = 1'b1;
    bit ok_hold = 1'b1;
    logic [W-1:0] y0, h0;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) ok_busy = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("sb_size", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("latency", lat, e.lat);
    if (e.lat > 1) check("busy_in_calc", ok_busy, 1);
    check("y", y, e.y);
    check("y_hi", y_hi, e.hi);
    check("carry_out", carry_out, e.c);
    check("div_by_zero", div_by_zero, e.dbz);
`ifdef ALU_FLAGS_EN
    check("flag_z", flag_z, (e.y == '0));
    check("flag_n", flag_n, e.y[W-1]);
    check("flag_v", flag_v, e.v);
`endif
    y0 = y;
    h0 = y_hi;
    for (int i = 0; i < hold; i++) begin
      if (compete && i == 0) begin
        opcode = OP_ADD; a = 4'h2; b = 4'h3; carry_in = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      if (y !== y0 || y_hi !== h0 || !out_valid || in_ready) ok_hold = 1'b0;
    end
    if (hold > 0) check("hold_stable", ok_hold, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    if (compete) begin
      check("ready_after_release", in_ready, 1);
      sb_q.push_back(model(OP_ADD, 4'h2, 4'h3, 1'b0, '0, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; shift_amt = '0; shift_dir = 1'b0; opcode = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y", {y_hi, y}, 0);
    check("rst_flags_cd", {carry_out, div_by_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(OP_ADD, 4'hF, 4'h1, 1'b0, '0, 1'b0); recv(0, 0);
    send(OP_SUB, 4'h3, 4'h5, 1'b0, '0, 1'b0); recv(0, 0);
    send(OP_MUL, 4'hD, 4'hB, 1'b0, '0, 1'b0); recv(0, 0);
    send(OP_DIV, 4'hD, 4'h4, 1'b0, '0, 1'b0); recv(0, 0);
    send(OP_DIV, 4'h7, 4'h0, 1'b0, '0, 1'b0); recv(0, 0);

    // Backpressure on a MUL result with a competing request held during DONE.
    send(OP_MUL, 4'hD, 4'hB, 1'b0, '0, 1'b0); recv(3, 1);
    recv(0, 0);

    send(OP_SHIFT, 4'h9, 4'h0, 1'b0, 2'd1, 1'b0); recv(0, 0);
    send(OP_SHIFT, 4'h9, 4'h0, 1'b0, 2'd3, 1'b1); recv(0, 0);
    send(OP_SHIFT, 4'h9, 4'h0, 1'b0, 2'd0, 1'b0); recv(0, 0);
    send(OP_ADD,   4'h7, 4'h1, 1'b0, '0, 1'b0);   recv(0, 0);
    send(OP_RSV,   4'h7, 4'h1, 1'b0, '0, 1'b0);   recv(0, 0);
    send(OP_NOT,   4'h5, 4'h0, 1'b0, '0, 1'b0);   recv(0, 0);

    // Reset on the second CALC cycle of a MUL discards it.
    send(OP_MUL, 4'hF, 4'hF, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_y", y, 0);
    check("midrst_y_hi", y_hi, 0);
    rst_n = 1'b1;
    void'(sb_q.pop_front());
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("no_stale_result", quiet, 1);

    for (int i = 0; i < 30; i++) begin
      send(4'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), SHW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      recv($urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
